// File: rtl/axi_hpm0_pkg.sv
// Shared AXI burst/response encodings, FSM state types and the beat-address
// step function used by the register-bank slave.
package axi_hpm0_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Illegal WRAP lengths step like INCR; the caller flags them as SLVERR.
  function automatic logic [63:0] next_beat_addr(input logic [63:0] addr,
                                                 input logic [2:0]  size,
                                                 input logic [7:0]  len,
                                                 input logic [1:0]  burst);
    logic [63:0] step;
    logic [63:0] mask;
    logic [63:0] nxt;
    step = 64'd1 << size;
    case (len)
      8'd1:    mask = (step << 1) - 64'd1;
      8'd3:    mask = (step << 2) - 64'd1;
      8'd7:    mask = (step << 3) - 64'd1;
      8'd15:   mask = (step << 4) - 64'd1;
      default: mask = 64'd0;
    endcase
    if (burst == BURST_FIXED) begin
      nxt = addr;
    end else if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
      nxt = (addr & ~mask) | ((addr + step) & mask);
    end else begin
      nxt = addr + step;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Registered beat-address generator: latches one AXI request, steps its
// address per beat and reports the word index, last beat and error flags.
module axi_burst_addr_gen
  import axi_hpm0_pkg::*;
#(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WORDS  = 256,
  parameter int IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_size,
  input  logic [7:0]            i_len,
  input  logic [1:0]            i_burst,
  input  logic                  i_advance,
  output logic [IDX_W-1:0]      o_word,
  output logic                  o_last,
  output logic                  o_range_err,
  output logic                  o_proto_err
);

  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_size;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [1:0]            r_burst;
  logic                  r_range_err;
  logic                  r_proto_err;
  logic [63:0]           w_next;
  logic                  w_unused;

  assign w_next   = next_beat_addr(64'(r_addr), r_size, r_len, r_burst);
  assign w_unused = ^w_next[63:ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_addr      <= '0;
      r_size      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_burst     <= '0;
      r_range_err <= 1'b0;
      r_proto_err <= 1'b0;
    end else if (i_load) begin
      r_addr      <= i_addr;
      r_size      <= i_size;
      r_len       <= i_len;
      r_beat      <= '0;
      r_burst     <= i_burst;
      // Any address bit above the bank span puts the whole burst out of range.
      r_range_err <= |i_addr[ADDR_WIDTH-1:BYTE_SHIFT+IDX_W];
      r_proto_err <= (i_burst == BURST_RSVD) ||
                     ((i_burst == BURST_WRAP) && !wrap_len_ok(i_len));
    end else if (i_advance) begin
      r_addr <= w_next[ADDR_WIDTH-1:0];
      r_beat <= r_beat + 8'd1;
    end
  end

  assign o_word      = r_addr[BYTE_SHIFT +: IDX_W];
  assign o_last      = (r_beat == r_len);
  assign o_range_err = r_range_err;
  assign o_proto_err = r_proto_err;

endmodule

// File: rtl/axi_hpm0_reg_slave.sv
// AXI4 register-bank slave for the PS HPM0_FPD master: one write and one read
// in flight, independent paths, plus a PL read port and write-commit strobe.
module axi_hpm0_reg_slave
  import axi_hpm0_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 40,
  parameter int ID_WIDTH   = 16,
  parameter int USER_WIDTH = 16,
  parameter int NUM_WORDS  = 256
) (
  input  logic                         pl_clk0,
  input  logic                         pl_resetn0,
  input  logic [ID_WIDTH-1:0]          s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [7:0]                   s_axi_awlen,
  input  logic [2:0]                   s_axi_awsize,
  input  logic [1:0]                   s_axi_awburst,
  input  logic                         s_axi_awlock,
  input  logic [3:0]                   s_axi_awcache,
  input  logic [2:0]                   s_axi_awprot,
  input  logic [3:0]                   s_axi_awqos,
  input  logic [USER_WIDTH-1:0]        s_axi_awuser,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
  input  logic                         s_axi_wlast,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [ID_WIDTH-1:0]          s_axi_bid,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arlock,
  input  logic [3:0]                   s_axi_arcache,
  input  logic [2:0]                   s_axi_arprot,
  input  logic [3:0]                   s_axi_arqos,
  input  logic [USER_WIDTH-1:0]        s_axi_aruser,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic [$clog2(NUM_WORDS)-1:0] usr_rd_addr,
  output logic [DATA_WIDTH-1:0]        usr_rd_data,
  output logic                         usr_wr_pulse,
  output logic [$clog2(NUM_WORDS)-1:0] usr_wr_addr,
  output logic [1:0]                   o_dbg_w_state,
  output logic [1:0]                   o_dbg_r_state
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  // Handshake rule on every channel: a transfer happens on the rising edge
  // where valid and ready are both high; a raised valid is never withdrawn
  // and its payload is held unchanged until that edge.

  logic [DATA_WIDTH-1:0] r_bank [NUM_WORDS];
  logic [DATA_WIDTH-1:0] r_usr_rd_data;
  logic                  r_usr_wr_pulse;
  logic [IDX_W-1:0]      r_usr_wr_addr;

  w_state_e         r_w_state, w_w_state_nxt;
  logic [ID_WIDTH-1:0] r_bid;
  logic [1:0]       r_bresp;
  logic             r_wlast_err;
  logic             w_aw_hs, w_w_hs, w_wlast_bad;
  logic [IDX_W-1:0] w_wgen_word;
  logic             w_wgen_last, w_wgen_range_err, w_wgen_proto_err;

  r_state_e         r_r_state, w_r_state_nxt;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]       r_rresp;
  logic             r_rlast;
  logic             w_ar_hs, w_r_hs;
  logic [IDX_W-1:0] w_rgen_word;
  logic             w_rgen_last, w_rgen_range_err, w_rgen_proto_err;

  logic             w_unused;
  assign w_unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awuser,
                      s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_aruser};

  assign w_aw_hs     = s_axi_awvalid && (r_w_state == W_IDLE);
  assign w_w_hs      = s_axi_wvalid && (r_w_state == W_DATA);
  assign w_wlast_bad = (s_axi_wlast != w_wgen_last);
  assign w_ar_hs     = s_axi_arvalid && (r_r_state == R_IDLE);
  assign w_r_hs      = s_axi_rready && (r_r_state == R_DATA);

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)
  ) u_wr_gen (
    .i_clk(pl_clk0), .i_rst_n(pl_resetn0), .i_load(w_aw_hs), .i_addr(s_axi_awaddr),
    .i_size(s_axi_awsize), .i_len(s_axi_awlen), .i_burst(s_axi_awburst), .i_advance(w_w_hs),
    .o_word(w_wgen_word), .o_last(w_wgen_last), .o_range_err(w_wgen_range_err),
    .o_proto_err(w_wgen_proto_err)
  );

  axi_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)
  ) u_rd_gen (
    .i_clk(pl_clk0), .i_rst_n(pl_resetn0), .i_load(w_ar_hs), .i_addr(s_axi_araddr),
    .i_size(s_axi_arsize), .i_len(s_axi_arlen), .i_burst(s_axi_arburst),
    .i_advance(w_r_hs && !r_rlast),
    .o_word(w_rgen_word), .o_last(w_rgen_last), .o_range_err(w_rgen_range_err),
    .o_proto_err(w_rgen_proto_err)
  );

  always_ff @(posedge pl_clk0) begin
    if (!pl_resetn0) begin
      r_w_state <= W_IDLE;
      r_r_state <= R_IDLE;
    end else begin
      r_w_state <= w_w_state_nxt;
      r_r_state <= w_r_state_nxt;
    end
  end

  always_comb begin
    w_w_state_nxt = r_w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        s_axi_awready = 1'b1;
        if (w_aw_hs) w_w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (w_w_hs && w_wgen_last) w_w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_w_state_nxt = W_IDLE;
      end
      default: w_w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_r_state_nxt = r_r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_r_state)
      R_IDLE: begin
        s_axi_arready = 1'b1;
        if (w_ar_hs) w_r_state_nxt = R_FETCH;
      end
      R_FETCH: w_r_state_nxt = R_DATA;
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (w_r_hs) w_r_state_nxt = r_rlast ? R_IDLE : R_FETCH;
      end
      default: w_r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge pl_clk0) begin
    if (!pl_resetn0) begin
      r_bid          <= '0;
      r_bresp        <= RESP_OKAY;
      r_wlast_err    <= 1'b0;
      r_usr_wr_pulse <= 1'b0;
      r_usr_wr_addr  <= '0;
    end else begin
      r_usr_wr_pulse <= w_w_hs && !w_wgen_range_err;
      if (w_w_hs && !w_wgen_range_err) r_usr_wr_addr <= w_wgen_word;
      if (w_aw_hs) begin
        r_bid       <= s_axi_awid;
        r_wlast_err <= 1'b0;
      end
      // A misplaced wlast only taints the response; len still sets the beat count.
      if (w_w_hs) begin
        r_wlast_err <= r_wlast_err | w_wlast_bad;
        if (w_wgen_last)
          r_bresp <= (w_wgen_range_err || w_wgen_proto_err || r_wlast_err || w_wlast_bad)
                     ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge pl_clk0) begin
    if (!pl_resetn0) begin
      for (int i = 0; i < NUM_WORDS; i++) r_bank[i] <= '0;
      r_usr_rd_data <= '0;
    end else begin
      r_usr_rd_data <= r_bank[usr_rd_addr];
      if (w_w_hs && !w_wgen_range_err) begin
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
          if (s_axi_wstrb[b]) r_bank[w_wgen_word][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
      end
    end
  end

  // rdata/rresp/rlast only change in R_FETCH, so they stay put under backpressure.
  always_ff @(posedge pl_clk0) begin
    if (!pl_resetn0) begin
      r_rid   <= '0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
      r_rlast <= 1'b0;
    end else begin
      if (w_ar_hs) r_rid <= s_axi_arid;
      if (r_r_state == R_FETCH) begin
        r_rdata <= w_rgen_range_err ? '0 : r_bank[w_rgen_word];
        r_rresp <= (w_rgen_range_err || w_rgen_proto_err) ? RESP_SLVERR : RESP_OKAY;
        r_rlast <= w_rgen_last;
      end
    end
  end

  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
  assign usr_rd_data   = r_usr_rd_data;
  assign usr_wr_pulse  = r_usr_wr_pulse;
  assign usr_wr_addr   = r_usr_wr_addr;
  assign o_dbg_w_state = r_w_state;
  assign o_dbg_r_state = r_r_state;

endmodule
